triangle_note_scheduler: RTL and testbench
==========================================

Name: triangle_note_scheduler

Overview:
Sequences the triangle channel through a note pattern stored in an external synchronous pattern memory. Each entry is fetched and its phase increment and gate driven to the phase generator. The note is held for its programmed number of frame ticks, then the next entry is fetched. Start/stop, end-of-pattern markers and optional looping are supported. Sits between pattern RAM/ROM and the triangle phase generator; replaces the fixed note sequencer.

Parameters:
PATTERN_LEN, 32, number of pattern entries (power of 2 not required, >=2)
ADDR_W, 5, pattern address width, must satisfy 2**ADDR_W >= PATTERN_LEN

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  reset
i_tick_stb  input  1  one-cycle frame tick strobe (note duration time base)
i_start  input  1  one-cycle pulse: begin playback at entry 0
i_stop  input  1  one-cycle pulse: abort playback
i_loop_en  input  1  1 = restart at entry 0 after end of pattern
o_rd_en  output  1  pattern memory read enable
o_rd_addr  output  ADDR_W  pattern memory read address
i_rd_data  input  32  entry: [31:8] phase increment, [7:0] duration in ticks
o_phase_delta  output  32  phase increment to phase generator, {8'b0, entry[31:8]}
o_phase_delta_valid  output  1  one-cycle pulse whenever o_phase_delta changes
o_gate  output  1  1 while a non-rest note plays
o_note_stb  output  1  one-cycle pulse when a new entry takes effect
o_busy  output  1  1 in any state except IDLE
o_done  output  1  one-cycle pulse when playback ends naturally

Behaviour:
- Reset: i_clk is the single clock; i_rst_n is asynchronous, active-low. All outputs 0, state IDLE, address 0, tick counter 0.
- Memory contract: i_rd_data is valid exactly one cycle after o_rd_en=1 (registered read). o_rd_en is a one-cycle pulse.
- Entry encoding: duration 0 = end-of-pattern marker (increment ignored). Increment 0 with duration >0 = rest: gate 0, o_phase_delta 0.
- States: IDLE, FETCH, WAIT, PLAY.
- IDLE: o_busy 0, o_gate 0, o_phase_delta 0.
  - i_start: addr<=0, go to FETCH.
- FETCH: assert o_rd_en with o_rd_addr=addr for one cycle, then go to WAIT.
- WAIT: sample i_rd_data.
  - If duration==0 and addr!=0 and i_loop_en: addr<=0, go to FETCH.
  - If duration==0 otherwise (includes marker at entry 0, so an empty pattern cannot spin): o_done pulse, clear gate/delta, go to IDLE.
  - Else load remaining<=duration, o_phase_delta<={8'b0,incr}, o_gate<=(incr!=0), o_note_stb pulse, go to PLAY.
  - o_phase_delta_valid pulses only if the new delta differs from the current value.
- PLAY: each i_tick_stb decrements remaining. On the tick where remaining==1, the entry ends:
  - If addr==PATTERN_LEN-1: with i_loop_en, addr<=0 and go to FETCH; without, o_done pulse, clear gate/delta, go to IDLE.
  - Else addr<=addr+1, go to FETCH.
- Previous note output is held through FETCH/WAIT. Inter-note gap is 2 cycles, with no gate drop.
- Latency: i_start to o_note_stb = 3 cycles (FETCH, WAIT, output registered on WAIT exit). End tick to next o_note_stb = 3 cycles.
- i_stop in any non-IDLE state: go to IDLE next cycle; gate 0; delta 0 (valid pulse if it was nonzero); no o_done. An outstanding read is discarded.
- Simultaneous events:
  - i_stop and i_start together: stop wins.
  - i_start while busy: ignored.
  - i_tick_stb outside PLAY: ignored.
  - i_loop_en is sampled at the moment the end condition is evaluated.
- Reset mid-playback forces all outputs to 0 immediately (asynchronous assert). Restart requires a new i_start.
- Counters: remaining is 8 bits and never underflows. Address increments are compared against PATTERN_LEN-1, never against 2**ADDR_W.

Test Plan:
- Pattern {0x001000/3, 0x002000/2, 0/0}, loop off, start, 1 tick every 10 cycles -> note_stb at start+3; delta 0x1000 for 3 ticks, then 0x2000 for 2 ticks; o_done once; busy 0; gate 0.
- Same pattern with loop on -> after entry 1 fetches addr 0 again; delta returns to 0x1000; no o_done; i_stop -> IDLE next cycle, delta 0, valid pulse, no done.
- Entry {0,4} between two notes -> gate 0 and delta 0 for exactly 4 ticks, then gate 1 with the next increment.
- Entry 0 = end marker, loop on -> o_done after 2 cycles in FETCH/WAIT; returns to IDLE; no re-fetch.
- All PATTERN_LEN entries duration 1, loop off -> addresses 0..31 fetched in order; done after entry 31; no address 32 ever driven.
- i_rst_n low during PLAY -> outputs 0 asynchronously; after release, i_tick_stb pulses cause no activity until i_start.

Source files
------------

// File: rtl/triangle_note_scheduler.sv
// Steps the triangle channel through a pattern memory: fetch entry, drive delta/gate, hold for N frame ticks.
// Latency: start or end-of-note tick to o_note_stb is 3 cycles; previous note output is held across the fetch.
// Backpressure: none; the memory answers one cycle after o_rd_en, and ticks outside PLAY are dropped.
module triangle_note_scheduler #(
    parameter int PATTERN_LEN = 32,
    parameter int ADDR_W      = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tick_stb,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop_en,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [31:0]       i_rd_data,
    output logic [31:0]       o_phase_delta,
    output logic              o_phase_delta_valid,
    output logic              o_gate,
    output logic              o_note_stb,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PATTERN_LEN - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        remaining;
    logic [31:0]       entry_delta;
    logic [7:0]        entry_dur;

    assign entry_delta = {8'b0, i_rd_data[31:8]};
    assign entry_dur   = i_rd_data[7:0];
    assign o_rd_addr   = addr;
    assign o_busy      = (state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state               <= S_IDLE;
            addr                <= '0;
            remaining           <= '0;
            o_rd_en             <= 1'b0;
            o_phase_delta       <= '0;
            o_phase_delta_valid <= 1'b0;
            o_gate              <= 1'b0;
            o_note_stb          <= 1'b0;
            o_done              <= 1'b0;
        end else begin
            o_rd_en             <= 1'b0;
            o_phase_delta_valid <= 1'b0;
            o_note_stb          <= 1'b0;
            o_done              <= 1'b0;
            if (i_stop) begin
                // Abort: any read already in flight is simply never sampled.
                if (state != S_IDLE) begin
                    state               <= S_IDLE;
                    remaining           <= '0;
                    o_gate              <= 1'b0;
                    o_phase_delta       <= '0;
                    o_phase_delta_valid <= (o_phase_delta != '0);
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            addr    <= '0;
                            o_rd_en <= 1'b1;
                            state   <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (entry_dur == 8'd0) begin
                            // A marker at entry 0 never loops, so an empty pattern cannot spin.
                            if (addr != '0 && i_loop_en) begin
                                addr    <= '0;
                                o_rd_en <= 1'b1;
                                state   <= S_FETCH;
                            end else begin
                                state               <= S_IDLE;
                                o_done              <= 1'b1;
                                o_gate              <= 1'b0;
                                o_phase_delta       <= '0;
                                o_phase_delta_valid <= (o_phase_delta != '0);
                            end
                        end else begin
                            remaining           <= entry_dur;
                            o_phase_delta       <= entry_delta;
                            o_phase_delta_valid <= (entry_delta != o_phase_delta);
                            o_gate              <= (entry_delta != '0);
                            o_note_stb          <= 1'b1;
                            state               <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (i_tick_stb && remaining != 8'd0) begin
                            remaining <= remaining - 8'd1;
                            if (remaining == 8'd1) begin
                                if (addr != LAST_ADDR) begin
                                    addr    <= addr + 1'b1;
                                    o_rd_en <= 1'b1;
                                    state   <= S_FETCH;
                                end else if (i_loop_en) begin
                                    addr    <= '0;
                                    o_rd_en <= 1'b1;
                                    state   <= S_FETCH;
                                end else begin
                                    state               <= S_IDLE;
                                    o_done              <= 1'b1;
                                    o_gate              <= 1'b0;
                                    o_phase_delta       <= '0;
                                    o_phase_delta_valid <= (o_phase_delta != '0);
                                end
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_triangle_note_scheduler.sv
// Bench for triangle_note_scheduler: directed pattern scenarios plus randomized playback,
// every output checked each cycle against a behavioural playback model.
module tb_triangle_note_scheduler;

    localparam int LEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_stb = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] phase_delta;
    logic        phase_delta_valid;
    logic        gate;
    logic        note_stb;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:LEN-1];

    triangle_note_scheduler #(.PATTERN_LEN(LEN), .ADDR_W(5)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_tick_stb          (tick_stb),
        .i_start             (start),
        .i_stop              (stop),
        .i_loop_en           (loop_en),
        .o_rd_en             (rd_en),
        .o_rd_addr           (rd_addr),
        .i_rd_data           (rd_data),
        .o_phase_delta       (phase_delta),
        .o_phase_delta_valid (phase_delta_valid),
        .o_gate              (gate),
        .o_note_stb          (note_stb),
        .o_busy              (busy),
        .o_done              (done)
    );

    always #5 clk = ~clk;

    // Registered-read pattern memory
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Tick generator: 0 = none, 1 = every tick_period cycles, 2 = random
    int tick_mode = 0;
    int tick_period = 10;
    always begin
        @(posedge clk);
        #1;
        case (tick_mode)
            1:       tick_stb = (cyc % tick_period == 0);
            2:       tick_stb = ($urandom % 3 == 0);
            default: tick_stb = 1'b0;
        endcase
    end

    // Behavioural playback model: a fetch takes two cycles before the entry is judged,
    // then the note lasts a number of accepted ticks.
    logic        m_busy, m_gate, m_valid, m_note, m_done, m_rd_en;
    logic [31:0] m_delta;
    logic [4:0]  m_rd_addr;
    int          fetch_left, idx, ticks_left;

    task automatic m_issue(input int i);
        idx        = i;
        fetch_left = 2;
        m_rd_en    = 1'b1;
        m_rd_addr  = 5'(i);
    endtask

    task automatic m_end(input logic with_done);
        m_valid    = (m_delta != 0);
        m_delta    = 0;
        m_gate     = 1'b0;
        m_busy     = 1'b0;
        fetch_left = 0;
        m_done     = with_done;
    endtask

    task automatic m_eval();
        logic [31:0] e;
        logic [31:0] nd;
        e          = mem[idx];
        fetch_left = 0;
        if (e[7:0] == 8'd0) begin
            if (idx != 0 && loop_en) m_issue(0);
            else m_end(1'b1);
        end else begin
            nd         = {8'b0, e[31:8]};
            ticks_left = int'(e[7:0]);
            m_valid    = (nd != m_delta);
            m_delta    = nd;
            m_gate     = (nd != 0);
            m_note     = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_gate = 0; m_valid = 0; m_note = 0; m_done = 0; m_rd_en = 0;
            m_delta = 0; m_rd_addr = 0; fetch_left = 0; idx = 0; ticks_left = 0;
        end else begin
            m_valid = 0; m_note = 0; m_done = 0; m_rd_en = 0;
            if (stop) begin
                if (m_busy) m_end(1'b0);
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_issue(0);
                end
            end else if (fetch_left == 2) begin
                fetch_left = 1;
            end else if (fetch_left == 1) begin
                m_eval();
            end else if (tick_stb) begin
                ticks_left--;
                if (ticks_left == 0) begin
                    if (idx != LEN - 1) m_issue(idx + 1);
                    else if (loop_en) m_issue(0);
                    else m_end(1'b1);
                end
            end
        end
    end

    // Statistics for the literal checks of directed scenarios
    int          note_cnt, done_cnt, valid_cnt, rd_cnt, t1000, t2000, rest_t, note_cyc, done_cyc;
    logic [31:0] note_delta [0:63];
    logic        note_gate  [0:63];
    logic [4:0]  rd_log     [0:63];

    task automatic clear_stats();
        note_cnt = 0; done_cnt = 0; valid_cnt = 0; rd_cnt = 0;
        t1000 = 0; t2000 = 0; rest_t = 0; note_cyc = -1; done_cyc = -1;
    endtask

    // Per-cycle compare against the model, plus statistics gathering
    always @(negedge clk) begin
        check("busy",     {31'b0, busy},              {31'b0, m_busy});
        check("gate",     {31'b0, gate},              {31'b0, m_gate});
        check("delta",    phase_delta,                m_delta);
        check("valid",    {31'b0, phase_delta_valid}, {31'b0, m_valid});
        check("note_stb", {31'b0, note_stb},          {31'b0, m_note});
        check("done",     {31'b0, done},              {31'b0, m_done});
        check("rd_en",    {31'b0, rd_en},             {31'b0, m_rd_en});
        if (m_rd_en) check("rd_addr", {27'b0, rd_addr}, {27'b0, m_rd_addr});

        if (note_stb) begin
            if (note_cnt == 0) note_cyc = cyc;
            if (note_cnt < 64) begin
                note_delta[note_cnt] = phase_delta;
                note_gate[note_cnt]  = gate;
            end
            note_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (phase_delta_valid) valid_cnt++;
        if (rd_en) begin
            if (rd_cnt < 64) rd_log[rd_cnt] = rd_addr;
            rd_cnt++;
        end
        if (tick_stb && gate && phase_delta == 32'h1000) t1000++;
        if (tick_stb && gate && phase_delta == 32'h2000) t2000++;
        if (tick_stb && busy && !gate && note_cnt == 2) rest_t++;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("wait_idle", {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_notes(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (note_cnt >= n) break;
        end
        check("wait_notes", {31'b0, (note_cnt >= n)}, 32'd1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < LEN; i++) mem[i] = 32'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    int s_cyc;
    int order_err;

    initial begin
        clear_mem();
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",  {31'b0, busy}, 32'd0);
        check("reset_delta", phase_delta,   32'd0);
        check("reset_rd_en", {31'b0, rd_en}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two notes then an end marker, no looping
        mem[0] = 32'h0010_0003; mem[1] = 32'h0020_0002; mem[2] = 32'h0;
        loop_en = 1'b0; tick_period = 10; tick_mode = 1;
        clear_stats();
        s_cyc = cyc;
        pulse_start();
        wait_idle(1000);
        @(posedge clk); #1;
        check("t1_latency", note_cyc - s_cyc, 32'd3);
        check("t1_notes",   note_cnt, 32'd2);
        check("t1_delta0",  note_delta[0], 32'h1000);
        check("t1_ticks1k", t1000, 32'd3);
        check("t1_ticks2k", t2000, 32'd2);
        check("t1_done",    done_cnt, 32'd1);
        check("t1_gate",    {31'b0, gate}, 32'd0);

        // Same pattern looping, then stopped
        loop_en = 1'b1;
        clear_stats();
        pulse_start();
        wait_notes(4, 1000);
        @(posedge clk); #1;
        check("t2_loop_delta", note_delta[2], 32'h1000);
        check("t2_no_done",    done_cnt, 32'd0);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        check("t2_stop_busy",  {31'b0, busy}, 32'd0);
        check("t2_stop_delta", phase_delta, 32'd0);
        check("t2_stop_valid", {31'b0, phase_delta_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t2_stop_nodone", done_cnt, 32'd0);

        // Rest between two notes
        clear_mem();
        mem[0] = 32'h0003_0002; mem[1] = 32'h0000_0004; mem[2] = 32'h0005_0001;
        loop_en = 1'b0; tick_period = 5;
        clear_stats();
        pulse_start();
        wait_idle(1000);
        @(posedge clk); #1;
        check("t3_rest_gate",  {31'b0, note_gate[1]}, 32'd0);
        check("t3_rest_delta", note_delta[1], 32'd0);
        check("t3_rest_ticks", rest_t, 32'd4);
        check("t3_next_delta", note_delta[2], 32'h500);
        check("t3_next_gate",  {31'b0, note_gate[2]}, 32'd1);

        // Empty pattern with looping enabled
        clear_mem();
        loop_en = 1'b1;
        clear_stats();
        s_cyc = cyc;
        pulse_start();
        wait_idle(100);
        repeat (5) @(posedge clk);
        #1;
        check("t4_done",       done_cnt, 32'd1);
        check("t4_done_lat",   done_cyc - s_cyc, 32'd3);
        check("t4_one_fetch",  rd_cnt, 32'd1);
        check("t4_no_note",    note_cnt, 32'd0);

        // Full-length pattern of one-tick notes
        for (int i = 0; i < LEN; i++) mem[i] = ((i + 1) << 8) | 1;
        loop_en = 1'b0; tick_period = 4;
        clear_stats();
        pulse_start();
        wait_idle(2000);
        @(posedge clk); #1;
        order_err = 0;
        for (int i = 0; i < LEN; i++) if (rd_log[i] != 5'(i)) order_err++;
        check("t5_fetches", rd_cnt, 32'd32);
        check("t5_order",   order_err, 32'd0);
        check("t5_notes",   note_cnt, 32'd32);
        check("t5_done",    done_cnt, 32'd1);

        // Asynchronous reset during playback
        clear_mem();
        mem[0] = 32'h0003_0002; mem[1] = 32'h0000_0004; mem[2] = 32'h0005_0001;
        loop_en = 1'b1; tick_period = 5;
        clear_stats();
        pulse_start();
        wait_notes(1, 100);
        check("t6_pre_gate", {31'b0, gate}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_gate",  {31'b0, gate}, 32'd0);
        check("t6_rst_delta", phase_delta, 32'd0);
        check("t6_rst_busy",  {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick_period = 2;
        @(posedge clk); #1;
        clear_stats();
        repeat (20) @(posedge clk);
        #1;
        check("t6_no_fetch", rd_cnt, 32'd0);
        check("t6_idle",     {31'b0, busy}, 32'd0);

        // Randomized playback against the model
        for (int i = 0; i < LEN; i++) begin
            logic [23:0] inc;
            inc = ($urandom % 4 == 0) ? 24'd0 : 24'($urandom);
            mem[i] = {inc, 8'($urandom % 4)};
        end
        mem[0][7:0] = 8'd2;
        tick_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            start   = ($urandom % 15 == 0);
            stop    = ($urandom % 80 == 0);
            loop_en = ($urandom % 2 == 0);
        end
        @(posedge clk);
        #1 start = 1'b0; stop = 1'b0;
        pulse_stop();
        wait_idle(20);
        tick_mode = 0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
